seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter. It is the driving end of the 1-bit-per-clock serial stream that our sequence detectors consume.
- Accepts a parallel pattern word over a valid/ready handshake.
- Shifts the selected bits out MSB-first, one bit per clock, optionally repeated with inter-repeat gaps.
- Used as the on-chip stimulus source for the detector blocks and as the serial front end for pattern loopback tests.

Parameters:
WIDTH, 8, maximum pattern length in bits (data word width).
LEN_W, 4, width of in_len; must satisfy 2**LEN_W > WIDTH.
REP_W, 4, width of in_rep (repeat count field).
GAP, 0, number of idle cycles (dout_valid=0) inserted between repetitions; 0 means repetitions are back-to-back.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  upstream has a pattern to load.
in_ready  output  1  block can accept a pattern; high only in IDLE.
in_data  input  WIDTH  pattern; bits [len-1:0] are sent.
in_len  input  LEN_W  number of bits to send; 0 or >WIDTH clamps to WIDTH.
in_rep  input  REP_W  extra repetitions; total sends = in_rep+1.
dout  output  1  serial bit; forced 0 when dout_valid=0.
dout_valid  output  1  dout carries a pattern bit this cycle.
busy  output  1  high in SEND or GAP.
done  output  1  one-cycle pulse, concurrent with the final bit of the final repetition.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE.
  - dout=0, dout_valid=0, busy=0, done=0, in_ready=1.
  - Shift register and all counters are cleared.
  - Applies from any state, including mid-send. The pattern is discarded and no done is produced.
- State encoding: IDLE, SEND, GAP. All outputs are registered, except in_ready, which equals (state==IDLE).
- IDLE:
  - On an edge with in_valid&&in_ready, capture in_data, the clamped length L and R=in_rep. Go to SEND.
  - The first bit, in_data[L-1], is driven with dout_valid=1 in the cycle immediately after the accepting edge. Latency is 1 cycle.
- SEND:
  - Drive bits in_data[L-1] down to in_data[0] on consecutive cycles.
  - bit_idx counts L-1 down to 0. rep_cnt counts R down to 0.
  - After bit 0:
    - if rep_cnt>0 and GAP>0: decrement rep_cnt, go to GAP.
    - if rep_cnt>0 and GAP=0: decrement rep_cnt, reload bit_idx=L-1 and stay in SEND. There is no bubble.
    - if rep_cnt=0: go to IDLE.
- GAP: hold dout=0, dout_valid=0, busy=1 for exactly GAP cycles, then return to SEND with bit_idx=L-1.
- done=1 only in the cycle carrying the last bit of the last repetition.
- Total dout_valid cycles per pattern = L*(R+1). Total busy cycles = L*(R+1) + GAP*R.
- Back-to-back patterns: in_ready returns high in the cycle after the last bit. At least one cycle separates consecutive patterns.
- in_valid while busy is ignored (in_ready=0). Upstream must hold in_data/in_len/in_rep stable until accepted.
- Held patterns are not affected by input changes after the accepting edge.
- Width rules:
  - L is computed at accept: L = (in_len==0 || in_len>WIDTH) ? WIDTH : in_len.
  - bit_idx is LEN_W wide.
  - rep_cnt is REP_W wide; it never underflows (decrements only when >0).
  - The GAP counter is sized to hold GAP; with GAP=0 it is unused and GAP is unreachable.

Decomposition:
- Shared package seq_pkg holds the state encoding constants (IDLE=2'd0, SEND=2'd1, GAP=2'd2) and the common serial-bit conventions used by the detectors.
- No sub-module is warranted. The clamp logic, counters and FSM stay in a single module.

Test Plan:
1. Reset: hold rst=1 for 2 cycles, then release.
   -> dout=0, dout_valid=0, busy=0, done=0, in_ready=1.
2. Load in_data=8'h0D, in_len=4, in_rep=0, GAP=0.
   -> dout=1,1,0,1 on 4 consecutive cycles starting the cycle after accept. done=1 on the 4th cycle; in_ready=1 on the 5th.
   -> A seq_detect_mealy driven by dout fires y on the 4th bit.
3. Load in_data=8'h0D, in_len=4, in_rep=2, GAP=0.
   -> 12 contiguous valid bits 110111011101. Detector pulses y on bits 4, 8 and 12. done only on bit 12.
4. Load in_data=8'hA5 with in_len=0, then again with in_len=12.
   -> Both send 8 bits 10100101, done on the 8th.
5. Build with GAP=2; load in_data=8'h05, in_len=3, in_rep=1.
   -> 1,0,1, then 2 cycles with dout_valid=0 and busy=1, then 1,0,1. done on the final bit; 8 busy cycles total.
6. Assert rst after 2 bits of test 2; separately assert in_valid with different data during busy.
   -> Reset case: next cycle all outputs are 0, in_ready=1, no done.
   -> Busy case: in_valid is ignored and the original pattern completes unchanged.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared FSM state encoding and serial-bit conventions for the pattern/detector blocks
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_e;

  // Level driven on a serial line whenever its valid qualifier is low.
  localparam logic SER_IDLE_BIT = 1'b0;

endpackage

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter: MSB-first shift-out with repeats and inter-repeat gaps
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic [REP_W-1:0] in_rep,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int GAP_CW = (GAP > 1) ? $clog2(GAP) : 1;

  seq_state_e        state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  bit_idx_q, bit_idx_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic [GAP_CW-1:0] gap_cnt_q, gap_cnt_d;
  logic              dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [LEN_W-1:0]  len_clamp;
  logic [WIDTH-1:0]  shifted;

  always_comb begin
    len_clamp = in_len;
    if (in_len == '0 || in_len > LEN_W'(WIDTH)) begin
      len_clamp = LEN_W'(WIDTH);
    end
  end

  // Outputs are registered from the next-state view, so the bit shown in a
  // cycle is always data_q[bit_idx_q] while in SEND.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    len_d     = len_q;
    bit_idx_d = bit_idx_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d    = in_data;
          len_d     = len_clamp;
          bit_idx_d = len_clamp - 1'b1;
          rep_cnt_d = in_rep;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bit_idx_q != '0) begin
          bit_idx_d = bit_idx_q - 1'b1;
        end else if (rep_cnt_q != '0) begin
          rep_cnt_d = rep_cnt_q - 1'b1;
          if (GAP > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end else begin
            bit_idx_d = len_q - 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (int'(gap_cnt_q) >= GAP - 1) begin
          state_d   = ST_SEND;
          bit_idx_d = len_q - 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    shifted      = data_d >> bit_idx_d;
    dout_valid_d = (state_d == ST_SEND);
    dout_d       = dout_valid_d ? shifted[0] : SER_IDLE_BIT;
    busy_d       = (state_d != ST_IDLE);
    done_d       = dout_valid_d && (bit_idx_d == '0) && (rep_cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      len_q        <= '0;
      bit_idx_q    <= '0;
      rep_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      dout_q       <= SER_IDLE_BIT;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      len_q        <= len_d;
      bit_idx_q    <= bit_idx_d;
      rep_cnt_q    <= rep_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed self-checking bench for seq_pattern_tx (GAP=0 and GAP=2 instances)
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid0, in_valid2;
  logic [7:0] in_data;
  logic [3:0] in_len;
  logic [3:0] in_rep;

  logic in_ready0, dout0, dout_valid0, busy0, done0;
  logic in_ready2, dout2, dout_valid2, busy2, done2;

  logic sel2;
  logic o_ready, o_dout, o_valid, o_busy, o_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(8), .LEN_W(4), .REP_W(4), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data), .in_len(in_len), .in_rep(in_rep),
    .dout(dout0), .dout_valid(dout_valid0), .busy(busy0), .done(done0)
  );

  seq_pattern_tx #(.WIDTH(8), .LEN_W(4), .REP_W(4), .GAP(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data), .in_len(in_len), .in_rep(in_rep),
    .dout(dout2), .dout_valid(dout_valid2), .busy(busy2), .done(done2)
  );

  always_comb begin
    o_ready = sel2 ? in_ready2   : in_ready0;
    o_dout  = sel2 ? dout2       : dout0;
    o_valid = sel2 ? dout_valid2 : dout_valid0;
    o_busy  = sel2 ? busy2       : busy0;
    o_done  = sel2 ? done2       : done0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".dout"},  {31'd0, o_dout},  32'd0);
    chk({tag, ".valid"}, {31'd0, o_valid}, 32'd0);
    chk({tag, ".busy"},  {31'd0, o_busy},  32'd0);
    chk({tag, ".done"},  {31'd0, o_done},  32'd0);
    chk({tag, ".ready"}, {31'd0, o_ready}, 32'd1);
  endtask

  // Loads one pattern and checks every cycle until the block is idle again.
  // poke holds in_valid high with different data during the first repetition.
  task automatic run_pattern(input bit g2, input logic [7:0] d, input logic [3:0] len,
                             input logic [3:0] rep, input int exp_l, input string tag,
                             input bit poke, output logic [31:0] bits, output int nbusy);
    int gap;
    int exp_bit;
    sel2    = g2;
    gap     = g2 ? 2 : 0;
    bits    = '0;
    nbusy   = 0;
    in_data = d;
    in_len  = len;
    in_rep  = rep;
    chk({tag, ".ready_pre"}, {31'd0, o_ready}, 32'd1);
    if (g2) in_valid2 = 1'b1; else in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    in_valid2 = 1'b0;
    for (int r = 0; r <= int'(rep); r++) begin
      for (int i = exp_l - 1; i >= 0; i--) begin
        exp_bit = int'(d[i]);
        chk($sformatf("%s.r%0d.b%0d.valid", tag, r, i), {31'd0, o_valid}, 32'd1);
        chk($sformatf("%s.r%0d.b%0d.dout", tag, r, i), {31'd0, o_dout}, exp_bit);
        chk($sformatf("%s.r%0d.b%0d.busy", tag, r, i), {31'd0, o_busy}, 32'd1);
        chk($sformatf("%s.r%0d.b%0d.ready", tag, r, i), {31'd0, o_ready}, 32'd0);
        chk($sformatf("%s.r%0d.b%0d.done", tag, r, i), {31'd0, o_done},
            (r == int'(rep) && i == 0) ? 32'd1 : 32'd0);
        bits = {bits[30:0], o_dout};
        if (o_busy) nbusy++;
        if (poke && r == 0) begin
          in_valid0 = (i != 0);
          in_data   = 8'hFF;
          in_len    = 4'd8;
          in_rep    = 4'd3;
        end
        tick();
      end
      if (r < int'(rep)) begin
        for (int g = 0; g < gap; g++) begin
          chk($sformatf("%s.gap%0d.valid", tag, g), {31'd0, o_valid}, 32'd0);
          chk($sformatf("%s.gap%0d.dout", tag, g), {31'd0, o_dout}, 32'd0);
          chk($sformatf("%s.gap%0d.busy", tag, g), {31'd0, o_busy}, 32'd1);
          if (o_busy) nbusy++;
          tick();
        end
      end
    end
    chk_idle({tag, ".post"});
  endtask

  initial begin
    logic [31:0] bits;
    int          nbusy;
    sel2      = 1'b0;
    rst       = 1'b1;
    in_valid0 = 1'b0;
    in_valid2 = 1'b0;
    in_data   = '0;
    in_len    = '0;
    in_rep    = '0;

    // 1: reset
    tick();
    tick();
    chk_idle("rst0");
    sel2 = 1'b1;
    chk_idle("rst2");
    rst = 1'b0;
    tick();
    sel2 = 1'b0;
    chk_idle("rel0");

    // 2: single 4-bit pattern
    run_pattern(1'b0, 8'h0D, 4'd4, 4'd0, 4, "p0D", 1'b0, bits, nbusy);
    chk("p0D.bits", bits, 32'h0000_000D);
    chk("p0D.busy_cycles", nbusy, 32'd4);

    // 3: two extra repeats, back-to-back
    tick();
    run_pattern(1'b0, 8'h0D, 4'd4, 4'd2, 4, "p0Dx3", 1'b0, bits, nbusy);
    chk("p0Dx3.bits", bits, 32'h0000_0DDD);
    chk("p0Dx3.busy_cycles", nbusy, 32'd12);

    // 4: length clamping
    run_pattern(1'b0, 8'hA5, 4'd0, 4'd0, 8, "lenzero", 1'b0, bits, nbusy);
    chk("lenzero.bits", bits, 32'h0000_00A5);
    run_pattern(1'b0, 8'hA5, 4'd12, 4'd0, 8, "lenbig", 1'b0, bits, nbusy);
    chk("lenbig.bits", bits, 32'h0000_00A5);

    // 5: GAP=2 instance
    run_pattern(1'b1, 8'h05, 4'd3, 4'd1, 3, "gap2", 1'b0, bits, nbusy);
    chk("gap2.bits", bits, 32'h0000_002D);
    chk("gap2.busy_cycles", nbusy, 32'd8);

    // 6a: reset after 2 bits
    sel2      = 1'b0;
    in_data   = 8'h0D;
    in_len    = 4'd4;
    in_rep    = 4'd0;
    in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    chk("midrst.b3", {31'd0, o_dout}, 32'd1);
    tick();
    chk("midrst.b2", {31'd0, o_dout}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("midrst.after");
    tick();
    chk_idle("midrst.after2");

    // 6b: in_valid during busy is ignored
    run_pattern(1'b0, 8'h0D, 4'd4, 4'd0, 4, "poke", 1'b1, bits, nbusy);
    chk("poke.bits", bits, 32'h0000_000D);
    tick();
    chk_idle("poke.settled");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
